// File: rtl/id_ex_reg_pkg.sv
// Shared encodings and control-bundle type for the ID/EX pipeline register.
package id_ex_reg_pkg;

    // ALU operation encodings carried in ALUControl.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    // Writeback result source selection.
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // Control bits and fields travelling with an instruction into E.
    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memwrite;
        logic       jump;
        logic       branch;
        logic       alusrc;
        logic [1:0] resultsrc;
        logic [3:0] alucontrol;
        logic [2:0] funct3;
    } ctrl_e_t;

    // A bubble is all zeros: not valid and no architectural side effects.
    localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_reg_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all ones.
module sat_counter #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    output logic [CNTW-1:0] count
);

    // Count up on inc unless already at the top value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush-to-bubble and hazard counters.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            ValidD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic            AluSrcD,
    input  logic [1:0]      ResultSrcD,
    input  logic [3:0]      ALUControlD,
    input  logic [2:0]      Funct3D,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    output logic            ValidE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            AluSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [3:0]      ALUControlE,
    output logic [2:0]      Funct3E,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic [CNTW-1:0] BubbleCntE,
    output logic [CNTW-1:0] HoldCntE
);

    ctrl_e_t ctrl_d;
    ctrl_e_t ctrl_q;
    logic    hold;
    logic    load_bubble;

    // Pack decode controls; work out hold/bubble shared by both registers.
    always_comb begin
        ctrl_d            = CTRL_BUBBLE;
        ctrl_d.valid      = ValidD;
        ctrl_d.regwrite   = RegWriteD;
        ctrl_d.memwrite   = MemWriteD;
        ctrl_d.jump       = JumpD;
        ctrl_d.branch     = BranchD;
        ctrl_d.alusrc     = AluSrcD;
        ctrl_d.resultsrc  = ResultSrcD;
        ctrl_d.alucontrol = ALUControlD;
        ctrl_d.funct3     = Funct3D;
        // Flush overrides stall; an invalid D slot is captured as a bubble.
        hold        = StallE & ~FlushE;
        load_bubble = FlushE | ~ValidD;
    end

    // Control register: bubble on reset/flush/invalid, hold on stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= CTRL_BUBBLE;
        end else if (!hold) begin
            ctrl_q <= load_bubble ? CTRL_BUBBLE : ctrl_d;
        end
    end

    // Datapath register: same enable and bubble logic as the control register.
    always_ff @(posedge clk) begin
        if (!rst_n || (!hold && load_bubble)) begin
            RD1E     <= '0;
            RD2E     <= '0;
            ImmExtE  <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
        end else if (!hold) begin
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            ImmExtE  <= ImmExtD;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            Rs1E     <= Rs1D;
            Rs2E     <= Rs2D;
            RdE      <= RdD;
        end
    end

    assign ValidE      = ctrl_q.valid;
    assign RegWriteE   = ctrl_q.regwrite;
    assign MemWriteE   = ctrl_q.memwrite;
    assign JumpE       = ctrl_q.jump;
    assign BranchE     = ctrl_q.branch;
    assign AluSrcE     = ctrl_q.alusrc;
    assign ResultSrcE  = ctrl_q.resultsrc;
    assign ALUControlE = ctrl_q.alucontrol;
    assign Funct3E     = ctrl_q.funct3;

    // Flush cycles count as bubbles; stall cycles count only when not flushed.
    sat_counter #(.CNTW(CNTW)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (FlushE),
        .count (BubbleCntE)
    );

    sat_counter #(.CNTW(CNTW)) u_hold_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hold),
        .count (HoldCntE)
    );

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: a default instance plus a 4-bit-counter instance.
module tb_id_ex_reg;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            StallE, FlushE, ValidD;
    logic            RegWriteD, MemWriteD, JumpD, BranchD, AluSrcD;
    logic [1:0]      ResultSrcD;
    logic [3:0]      ALUControlD;
    logic [2:0]      Funct3D;
    logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic [4:0]      Rs1D, Rs2D, RdD;

    logic            ValidE, RegWriteE, MemWriteE, JumpE, BranchE, AluSrcE;
    logic [1:0]      ResultSrcE;
    logic [3:0]      ALUControlE;
    logic [2:0]      Funct3E;
    logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]      Rs1E, Rs2E, RdE;
    logic [15:0]     BubbleCntE, HoldCntE;

    logic            n_ValidE, n_RegWriteE, n_MemWriteE, n_JumpE, n_BranchE, n_AluSrcE;
    logic [1:0]      n_ResultSrcE;
    logic [3:0]      n_ALUControlE;
    logic [2:0]      n_Funct3E;
    logic [XLEN-1:0] n_RD1E, n_RD2E, n_ImmExtE, n_PCE, n_PCPlus4E;
    logic [4:0]      n_Rs1E, n_Rs2E, n_RdE;
    logic [3:0]      n_BubbleCntE, n_HoldCntE;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_reg #(.XLEN(XLEN), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .AluSrcD(AluSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
        .Funct3D(Funct3D), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .AluSrcE(AluSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E),
        .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .BubbleCntE(BubbleCntE), .HoldCntE(HoldCntE)
    );

    id_ex_reg #(.XLEN(XLEN), .CNTW(4)) dut_n (
        .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .AluSrcD(AluSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
        .Funct3D(Funct3D), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ValidE(n_ValidE), .RegWriteE(n_RegWriteE), .MemWriteE(n_MemWriteE),
        .JumpE(n_JumpE), .BranchE(n_BranchE), .AluSrcE(n_AluSrcE),
        .ResultSrcE(n_ResultSrcE), .ALUControlE(n_ALUControlE), .Funct3E(n_Funct3E),
        .RD1E(n_RD1E), .RD2E(n_RD2E), .ImmExtE(n_ImmExtE), .PCE(n_PCE),
        .PCPlus4E(n_PCPlus4E), .Rs1E(n_Rs1E), .Rs2E(n_Rs2E), .RdE(n_RdE),
        .BubbleCntE(n_BubbleCntE), .HoldCntE(n_HoldCntE)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d_zero();
        ValidD = 0; RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; AluSrcD = 0;
        ResultSrcD = '0; ALUControlD = '0; Funct3D = '0;
        RD1D = '0; RD2D = '0; ImmExtD = '0; PCD = '0; PCPlus4D = '0;
        Rs1D = '0; Rs2D = '0; RdD = '0;
    endtask

    initial begin
        // Reset with every D input and both hazard controls at 1.
        rst_n = 0; StallE = 1; FlushE = 1;
        ValidD = 1; RegWriteD = 1; MemWriteD = 1; JumpD = 1; BranchD = 1; AluSrcD = 1;
        ResultSrcD = '1; ALUControlD = '1; Funct3D = '1;
        RD1D = '1; RD2D = '1; ImmExtD = '1; PCD = '1; PCPlus4D = '1;
        Rs1D = '1; Rs2D = '1; RdD = '1;
        tick(); tick();
        check("rst_valid", ValidE, 0);
        check("rst_regwrite", RegWriteE, 0);
        check("rst_memwrite", MemWriteE, 0);
        check("rst_jump_branch", {JumpE, BranchE, AluSrcE}, 0);
        check("rst_ctrl_fields", {ResultSrcE, ALUControlE, Funct3E}, 0);
        check("rst_data", {RD1E, RD2E}, 0);
        check("rst_pcs_imm", {ImmExtE ^ PCE ^ PCPlus4E}, 0);
        check("rst_regidx", {Rs1E, Rs2E, RdE}, 0);
        check("rst_bubblecnt", BubbleCntE, 0);
        check("rst_holdcnt", HoldCntE, 0);

        // Pass-through: add x5,x6,x7.
        rst_n = 1; StallE = 0; FlushE = 0;
        set_d_zero();
        ValidD = 1; RegWriteD = 1; ALUControlD = 4'b0000; RdD = 5'd5; Rs1D = 5'd6; Rs2D = 5'd7;
        RD1D = 32'd3; RD2D = 32'd4; PCD = 32'h1000; PCPlus4D = 32'h1004; ImmExtD = 32'hFFFF_FFF0;
        Funct3D = 3'b010; ResultSrcD = 2'b10;
        tick();
        check("pass_regwrite", RegWriteE, 1);
        check("pass_rd", RdE, 5);
        check("pass_rd1", RD1E, 3);
        check("pass_rd2", RD2E, 4);
        check("pass_valid", ValidE, 1);
        check("pass_rs", {Rs1E, Rs2E}, {5'd6, 5'd7});
        check("pass_pcs", {PCE, PCPlus4E}, {32'h1000, 32'h1004});
        check("pass_imm", ImmExtE, 32'hFFFF_FFF0);
        check("pass_fields", {ResultSrcE, ALUControlE, Funct3E}, {2'b10, 4'b0000, 3'b010});

        // Invalid capture loads a bubble without counting it.
        ValidD = 0; RegWriteD = 1; MemWriteD = 1; RdD = 5'd12; RD1D = 32'd77;
        tick();
        check("inval_valid", ValidE, 0);
        check("inval_writes", {RegWriteE, MemWriteE}, 0);
        check("inval_rd", RdE, 0);
        check("inval_rd1", RD1E, 0);
        check("inval_bubblecnt", BubbleCntE, 0);

        // Stall for three cycles while PCD keeps changing.
        set_d_zero();
        ValidD = 1; PCD = 32'h40; RegWriteD = 1; RdD = 5'd3;
        tick();
        check("stall_load_pc", PCE, 32'h40);
        StallE = 1;
        for (int i = 0; i < 3; i++) begin
            PCD = 32'h100 + 32'(i * 4);
            RdD = 5'(20 + i);
            tick();
        end
        check("stall_pc_held", PCE, 32'h40);
        check("stall_rd_held", RdE, 3);
        check("stall_holdcnt", HoldCntE, 3);
        check("stall_bubblecnt", BubbleCntE, 0);

        // Flush and stall together: flush wins.
        set_d_zero();
        ValidD = 1; MemWriteD = 1; RdD = 5'd9; StallE = 1; FlushE = 1;
        tick();
        check("flush_memwrite", MemWriteE, 0);
        check("flush_rd", RdE, 0);
        check("flush_valid", ValidE, 0);
        check("flush_pc", PCE, 0);
        check("flush_bubblecnt", BubbleCntE, 1);
        check("flush_holdcnt", HoldCntE, 3);

        // Hold the bubble across two stall cycles.
        FlushE = 0; StallE = 1; RegWriteD = 1;
        tick(); tick();
        check("holdbub_valid", ValidE, 0);
        check("holdbub_writes", {RegWriteE, MemWriteE}, 0);
        check("holdbub_holdcnt", HoldCntE, 5);

        // Mid-stall reset.
        set_d_zero();
        StallE = 0; ValidD = 1; RegWriteD = 1; RdD = 5'd11;
        tick();
        check("midrst_capture", RegWriteE, 1);
        StallE = 1; RdD = 5'd0;
        tick();
        check("midrst_holdcnt_pre", HoldCntE, 6);
        rst_n = 0;
        #1;
        check("midrst_no_async", RegWriteE, 1);
        tick();
        check("midrst_regwrite", RegWriteE, 0);
        check("midrst_holdcnt", HoldCntE, 0);
        check("midrst_bubblecnt", BubbleCntE, 0);
        check("midrst_rd", RdE, 0);

        // First capture after reset follows normal latency.
        rst_n = 1; StallE = 0;
        set_d_zero();
        ValidD = 1; RegWriteD = 1; RdD = 5'd7; RD1D = 32'hDEAD_BEEF;
        tick();
        check("postrst_rd", RdE, 7);
        check("postrst_rd1", RD1E, 32'hDEAD_BEEF);
        check("postrst_valid", {ValidE, RegWriteE}, 2'b11);

        // Saturation: 20 flush cycles; the 4-bit instance sticks at 15.
        rst_n = 0;
        tick();
        check("sat_rst_n", n_BubbleCntE, 0);
        rst_n = 1; FlushE = 1; StallE = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14) check("sat_reach15", n_BubbleCntE, 15);
            if (i == 15) check("sat_stay15", n_BubbleCntE, 15);
        end
        check("sat_final_n", n_BubbleCntE, 15);
        check("sat_final_wide", BubbleCntE, 20);
        check("sat_holdcnt_n", n_HoldCntE, 0);
        check("sat_valid_n", n_ValidE, 0);

        // Hold counter saturation on the narrow instance.
        FlushE = 0; StallE = 1;
        for (int i = 0; i < 18; i++) tick();
        check("satH_n", n_HoldCntE, 15);
        check("satH_wide", HoldCntE, 18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 The block SHALL have parameter CNTW, default 16, meaning hazard-counter width.
REQ-003 Port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port StallE, input, 1: hold current E-stage contents.
REQ-006 Port FlushE, input, 1: replace next E-stage contents with a bubble.
REQ-007 Port ValidD, input, 1: D-stage holds a real instruction.
REQ-008 Ports RegWriteD, MemWriteD, JumpD, BranchD, AluSrcD, input, 1 each: decode control bits.
REQ-009 Ports ResultSrcD, input, 2; ALUControlD, input, 4; Funct3D, input, 3: decode control fields.
REQ-010 Ports RD1D, RD2D, ImmExtD, PCD, PCPlus4D, input, XLEN each: operands, immediate, PCs.
REQ-011 Ports Rs1D, Rs2D, RdD, input, 5 each: register indices.
REQ-012 Outputs: E-suffixed copies of every D input in REQ-007 to REQ-011, identical widths (ValidE, RegWriteE ... RdE).
REQ-013 Ports BubbleCntE, HoldCntE, output, CNTW each: saturating counts of flush bubbles and stall cycles.

Function
REQ-014 Latency: with StallE=0 and FlushE=0, every E output SHALL equal its D input one clock after capture.
REQ-015 Stall: with StallE=1 and FlushE=0, all E outputs SHALL keep their values; HoldCntE SHALL increment by 1.
REQ-016 Flush: with FlushE=1, StallE SHALL be ignored (flush has priority).
REQ-017 Flush load value: ValidE, RegWriteE, MemWriteE, JumpE and BranchE SHALL be 0; all other E fields SHALL be 0 (ResultSrcE=00, ALUControlE=0000, RdE=0).
REQ-018 Flush counting: BubbleCntE SHALL increment by 1 per flush cycle.
REQ-019 Invalid capture: on a normal capture with ValidD=0, the stage SHALL load the bubble value of REQ-017 and SHALL NOT increment BubbleCntE.
REQ-020 Bubble effect: a bubble SHALL never produce an architectural write; RegWriteE=0 and MemWriteE=0 whenever ValidE=0.
REQ-021 Saturation: both counters SHALL stop at all ones and SHALL NOT wrap to 0.
REQ-022 Simultaneous StallE=1 and FlushE=1: bubble loaded; BubbleCntE increments; HoldCntE does not.
REQ-023 Hold consistency: the ValidE=0 invariant SHALL persist across any number of stall cycles.

Reset
REQ-024 When rst_n=0 at a clock edge, all E outputs and both counters SHALL load 0, regardless of StallE or FlushE.
REQ-025 Reset mid-stall or mid-flush SHALL discard the held instruction; the first capture after rst_n=1 follows REQ-014.
REQ-026 Outputs SHALL NOT change asynchronously; reset takes effect only at the rising edge of clk.

Structure
REQ-027 A shared package SHALL hold ALUControl encodings (ADD=0000 ... SLTU=1001), ResultSrc encodings, and a packed struct ctrl_e_t grouping the control fields plus its bubble constant CTRL_BUBBLE.
REQ-028 The saturating counter SHALL be one sub-module, sat_counter (parameter CNTW; inputs clk, rst_n, inc; output count), instantiated twice.
REQ-029 Datapath fields SHALL be held in a separate register from the control struct; both share the same enable and flush logic.

Verification
REQ-030 Reset: rst_n=0 for 2 cycles with all D inputs at 1 -> all E outputs 0; BubbleCntE=0; HoldCntE=0.
REQ-031 Pass-through: add x5,x6,x7 decoded (RegWriteD=1, ALUControlD=0000, RdD=5, RD1D=3, RD2D=4, ValidD=1) -> next cycle RegWriteE=1, RdE=5, RD1E=3, RD2E=4, ValidE=1.
REQ-032 Stall: load PCD=0x40, then StallE=1 for 3 cycles while PCD changes -> PCE stays 0x40; HoldCntE=3.
REQ-033 Flush with MemWriteD=1, RdD=9 and StallE=1 asserted together -> next cycle MemWriteE=0, RdE=0, ValidE=0; BubbleCntE=1; HoldCntE unchanged.
REQ-034 Saturation: CNTW=4, FlushE=1 for 20 cycles -> BubbleCntE reaches 15 and remains 15.
REQ-035 Mid-stall reset: StallE=1 holding RegWriteE=1, then rst_n=0 for one cycle -> RegWriteE=0 and HoldCntE=0 at the next edge.
